// File: rtl/wake_sched.sv
// wake_sched: producer of the per-lane Wake_Info broadcast.
// Each of the four issue lanes (ALU0, ALU1, LSU, MDU) owns a short delay
// line of wake slots. A uop accepted with latency L lands in slot L after
// the shift, so it reaches slot 0 and is broadcast exactly L+1 cycles later.
module wake_sched #(
  parameter int PRF_AW    = 6,
  parameter int LAT_DEPTH = 4,
  parameter int LAT_W     = $clog2(LAT_DEPTH),
  parameter int CNT_W     = $clog2(4*LAT_DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [3:0]            iss_valid,
  input  logic [3:0]            iss_wen,
  input  logic [4*PRF_AW-1:0]   iss_prd,
  input  logic [4*LAT_W-1:0]    iss_lat,
  output logic [3:0]            iss_rdy,
  output logic                  wen_0,
  output logic                  wen_1,
  output logic                  wen_2,
  output logic                  wen_3,
  output logic [PRF_AW-1:0]     wb_num0_i,
  output logic [PRF_AW-1:0]     wb_num1_i,
  output logic [PRF_AW-1:0]     wb_num2_i,
  output logic [PRF_AW-1:0]     wb_num3_i,
  output logic [CNT_W-1:0]      pend_cnt
);

  localparam int LANES = 4;

  logic [LAT_DEPTH-1:0] slot_v_q   [LANES];
  logic [LAT_DEPTH-1:0] slot_v_d   [LANES];
  logic [PRF_AW-1:0]    slot_tag_q [LANES][LAT_DEPTH];
  logic [PRF_AW-1:0]    slot_tag_d [LANES][LAT_DEPTH];
  logic [CNT_W-1:0]     pend_cnt_q;
  logic [CNT_W-1:0]     pend_cnt_d;

  logic [LAT_W-1:0]     lat_s        [LANES];
  logic [PRF_AW-1:0]    prd_s        [LANES];
  logic [LAT_DEPTH-1:0] busy_above_s [LANES];
  logic [3:0]           rdy_s;
  logic [3:0]           acc_s;

  // Ready/accept per lane: slot L of the post-shift state comes from slot L+1
  // today, so a set bit there means an older, longer wake would collide.
  // The top slot always shifts out empty, which makes L==LAT_DEPTH-1 always ready.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lat_s[k]        = iss_lat[k*LAT_W +: LAT_W];
      prd_s[k]        = iss_prd[k*PRF_AW +: PRF_AW];
      busy_above_s[k] = {1'b0, slot_v_q[k][LAT_DEPTH-1:1]};
      rdy_s[k]        = !iss_wen[k] || !busy_above_s[k][lat_s[k]];
      acc_s[k]        = iss_valid[k] && rdy_s[k] && iss_wen[k];
    end
  end

  // Next slot state: flush empties everything, an accept fills slot L,
  // otherwise each slot takes its upper neighbour and the top slot empties.
  always_comb begin
    pend_cnt_d = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int d = 0; d < LAT_DEPTH; d++) begin
        if (flush) begin
          slot_v_d[k][d]   = 1'b0;
          slot_tag_d[k][d] = '0;
        end else if (acc_s[k] && (lat_s[k] == LAT_W'(d))) begin
          slot_v_d[k][d]   = 1'b1;
          slot_tag_d[k][d] = prd_s[k];
        end else if (d < LAT_DEPTH-1) begin
          slot_v_d[k][d]   = busy_above_s[k][d];
          slot_tag_d[k][d] = slot_tag_q[k][(d < LAT_DEPTH-1) ? d+1 : d];
        end else begin
          slot_v_d[k][d]   = 1'b0;
          slot_tag_d[k][d] = '0;
        end
        pend_cnt_d = pend_cnt_d + CNT_W'(slot_v_d[k][d]);
      end
    end
  end

  // Slot registers and occupancy count, synchronously cleared by rst==0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < LANES; k++) begin
        slot_v_q[k] <= '0;
        for (int d = 0; d < LAT_DEPTH; d++) begin
          slot_tag_q[k][d] <= '0;
        end
      end
      pend_cnt_q <= '0;
    end else begin
      slot_v_q   <= slot_v_d;
      slot_tag_q <= slot_tag_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Empty slots always carry a zero tag, so wb_num is 0 whenever wen is 0.
  assign wen_0     = slot_v_q[0][0];
  assign wen_1     = slot_v_q[1][0];
  assign wen_2     = slot_v_q[2][0];
  assign wen_3     = slot_v_q[3][0];
  assign wb_num0_i = slot_tag_q[0][0];
  assign wb_num1_i = slot_tag_q[1][0];
  assign wb_num2_i = slot_tag_q[2][0];
  assign wb_num3_i = slot_tag_q[3][0];
  assign iss_rdy   = rdy_s;
  assign pend_cnt  = pend_cnt_q;

endmodule
